// File: rtl/timer8254_pkg.sv
// Shared definitions for the 8254 timer channel blocks.
//   DATA_W      : byte width of the CPU bus and of each count half
//   RW_*        : encodings of the control-word read/write field
//   BYTE_LSB/MSB: byte-select values used by the LSB/MSB sequencers
package timer8254_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] RW_LATCH   = 2'b00;
  localparam logic [1:0] RW_LSB     = 2'b01;
  localparam logic [1:0] RW_MSB     = 2'b10;
  localparam logic [1:0] RW_LSB_MSB = 2'b11;

  localparam logic BYTE_LSB = 1'b0;
  localparam logic BYTE_MSB = 1'b1;

endpackage

// File: rtl/byte_seq.sv
// LSB/MSB byte sequencer for one 8254 channel access path.
// Holds the RW mode register and the byte-select flip-flop.
// It is shared by the read path and the write path.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   mode_load   : control-word strobe for this channel
//   rw_in       : RW field of that control word; a value of 00 is ignored
//   advance     : one byte of the sequence is consumed this cycle
//   rw_reg      : current RW mode (debug/visibility)
//   byte_sel    : raw byte-select flip-flop (debug/visibility)
//   cur_byte    : byte the current access addresses
//   last_byte   : current byte completes the access sequence
module byte_seq
  import timer8254_pkg::*;
#(
  parameter logic [1:0] RW_RESET = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_load,
  input  logic [1:0] rw_in,
  input  logic       advance,
  output logic [1:0] rw_reg,
  output logic       byte_sel,
  output logic       cur_byte,
  output logic       last_byte
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_reg   <= RW_RESET;
      byte_sel <= BYTE_LSB;
    end else if (mode_load && (rw_in != RW_LATCH)) begin
      rw_reg   <= rw_in;
      byte_sel <= BYTE_LSB;
    end else if (advance && (rw_reg == RW_LSB_MSB)) begin
      byte_sel <= ~byte_sel;
    end
  end

  // Single-byte modes always address their fixed byte.
  // Two-byte mode follows the toggle flip-flop.
  always_comb begin
    cur_byte  = byte_sel;
    last_byte = 1'b1;
    case (rw_reg)
      RW_LSB:     cur_byte = BYTE_LSB;
      RW_MSB:     cur_byte = BYTE_MSB;
      RW_LSB_MSB: last_byte = (byte_sel == BYTE_MSB);
      default:    cur_byte = byte_sel;
    endcase
  end

endmodule

// File: rtl/count_readback.sv
// CPU-side read path of one 8254 counter channel.
// Serves the live count, a latched count or a latched status byte on an
// 8-bit read port, following the control-word RW mode.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   count_high/low    : live count from the counting element
//   status_in         : live status byte
//   mode_write        : control-word strobe; rw_mode is sampled with it
//   latch_cmd         : counter latch command strobe
//   status_latch      : read-back status latch strobe
//   rd                : CPU consumes the byte on data_out
//   data_out          : byte the next rd returns (combinational)
//   count_latched     : a count latch is held
//   status_pending    : a status latch is held
//
// Read handshake: data_out is always valid and rd is always accepted.
// A high rd on a rising edge consumes exactly the byte shown on data_out
// during that cycle. Status takes precedence over count bytes.
module count_readback
  import timer8254_pkg::*;
#(
  parameter int         DATA_W   = timer8254_pkg::DATA_W,
  parameter logic [1:0] RW_RESET = 2'b11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] count_high,
  input  logic [DATA_W-1:0] count_low,
  input  logic [DATA_W-1:0] status_in,
  input  logic              mode_write,
  input  logic [1:0]        rw_mode,
  input  logic              latch_cmd,
  input  logic              status_latch,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              count_latched,
  output logic              status_pending
);

  logic [DATA_W-1:0] latch_hi;
  logic [DATA_W-1:0] latch_lo;
  logic [DATA_W-1:0] status_reg;

  logic       mode_eff;
  logic       count_rd;
  logic [1:0] rw_reg;
  logic       byte_sel;
  logic       cur_byte;
  logic       last_byte;
  logic       latched_after_rd;
  logic       pending_after_rd;

  // An RW field of 00 is the latch command and has its own strobe.
  assign mode_eff = mode_write && (rw_mode != RW_LATCH);
  // A read consumes a count byte only if no status is waiting.
  assign count_rd = rd && !status_pending;

  byte_seq #(
    .RW_RESET (RW_RESET)
  ) u_byte_seq (
    .clk       (clk),
    .reset     (reset),
    .mode_load (mode_write),
    .rw_in     (rw_mode),
    .advance   (count_rd),
    .rw_reg    (rw_reg),
    .byte_sel  (byte_sel),
    .cur_byte  (cur_byte),
    .last_byte (last_byte)
  );

  // Read effects are resolved first, so a latch command on the same
  // edge as the final byte read starts a fresh latch.
  assign latched_after_rd = count_latched && !(count_rd && last_byte);
  assign pending_after_rd = status_pending && !rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_latched  <= 1'b0;
      status_pending <= 1'b0;
      latch_hi       <= '0;
      latch_lo       <= '0;
      status_reg     <= '0;
    end else if (mode_eff) begin
      count_latched  <= 1'b0;
      status_pending <= 1'b0;
    end else begin
      if (latch_cmd && !latched_after_rd) begin
        latch_hi      <= count_high;
        latch_lo      <= count_low;
        count_latched <= 1'b1;
      end else begin
        count_latched <= latched_after_rd;
      end

      if (status_latch && !pending_after_rd) begin
        status_reg     <= status_in;
        status_pending <= 1'b1;
      end else begin
        status_pending <= pending_after_rd;
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (status_pending) begin
      data_out = status_reg;
    end else if (cur_byte == BYTE_MSB) begin
      data_out = count_latched ? latch_hi : count_high;
    end else begin
      data_out = count_latched ? latch_lo : count_low;
    end
  end

  logic unused_dbg;
  assign unused_dbg = ^{rw_reg, byte_sel};

endmodule

// File: tb/tb_count_readback.sv
module tb_count_readback;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] count_high = '0;
  logic [W-1:0] count_low  = '0;
  logic [W-1:0] status_in  = '0;
  logic         mode_write = 1'b0;
  logic [1:0]   rw_mode    = 2'b00;
  logic         latch_cmd  = 1'b0;
  logic         status_latch = 1'b0;
  logic         rd = 1'b0;
  logic [W-1:0] data_out;
  logic         count_latched;
  logic         status_pending;

  count_readback dut (
    .clk            (clk),
    .reset          (reset),
    .count_high     (count_high),
    .count_low      (count_low),
    .status_in      (status_in),
    .mode_write     (mode_write),
    .rw_mode        (rw_mode),
    .latch_cmd      (latch_cmd),
    .status_latch   (status_latch),
    .rd             (rd),
    .data_out       (data_out),
    .count_latched  (count_latched),
    .status_pending (status_pending)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  string name_q[$];

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && rd) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: data_out=%02h, no expected byte queued", data_out);
      end else begin
        logic [W-1:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL %s: data_out=%02h expected=%02h", n, data_out, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge and hold for one cycle.
  task automatic cyc(input logic r, input logic lc, input logic sl,
                     input logic mw, input logic [1:0] rwm,
                     input logic [W-1:0] exp_byte, input string n);
    rd = r; latch_cmd = lc; status_latch = sl; mode_write = mw; rw_mode = rwm;
    if (r) begin
      exp_q.push_back(exp_byte);
      name_q.push_back(n);
    end
    @(posedge clk); #1;
    rd = 1'b0; latch_cmd = 1'b0; status_latch = 1'b0; mode_write = 1'b0; rw_mode = 2'b00;
  endtask

  task automatic do_rd(input logic [W-1:0] e, input string n);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, e, n);
  endtask

  task automatic do_latch();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, '0, "");
  endtask

  task automatic do_mode(input logic [1:0] m);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, m, '0, "");
  endtask

  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got=%02h expected=%02h", n, act, e);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    count_high = 8'h12; count_low = 8'h34;
    #12;
    chk("reset_latched", {7'd0, count_latched}, 8'h00);
    chk("reset_status",  {7'd0, status_pending}, 8'h00);
    chk("reset_data",    data_out, 8'h34);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Unlatched two-byte read.
    do_rd(8'h34, "t1_lsb");
    do_rd(8'h12, "t1_msb");
    chk("t1_latched", {7'd0, count_latched}, 8'h00);

    // Latched read while the count moves.
    do_latch();
    chk("t2_latched_set", {7'd0, count_latched}, 8'h01);
    count_low = 8'h00;
    do_rd(8'h34, "t2_lsb");
    chk("t2_latched_mid", {7'd0, count_latched}, 8'h01);
    do_rd(8'h12, "t2_msb");
    chk("t2_latched_clr", {7'd0, count_latched}, 8'h00);
    do_rd(8'h00, "t2_live_lsb");
    do_mode(2'b11);  // back to LSB

    // Second latch while held is ignored.
    count_high = 8'h12; count_low = 8'h34;
    do_latch();
    count_high = 8'h0F; count_low = 8'h00;
    do_latch();
    do_rd(8'h34, "t3_lsb");
    do_rd(8'h12, "t3_msb");
    chk("t3_latched_clr", {7'd0, count_latched}, 8'h00);

    // Status plus count latch together.
    status_in = 8'hB6; count_high = 8'h00; count_low = 8'hAA;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, '0, "");
    chk("t4_pending_set", {7'd0, status_pending}, 8'h01);
    status_in = 8'h11; count_low = 8'h55;
    do_rd(8'hB6, "t4_status");
    chk("t4_pending_clr", {7'd0, status_pending}, 8'h00);
    do_rd(8'hAA, "t4_lsb");
    do_rd(8'h00, "t4_msb");
    chk("t4_latched_clr", {7'd0, count_latched}, 8'h00);

    // Single-byte modes and the ignored 00 encoding.
    count_high = 8'hAB; count_low = 8'hCD;
    do_mode(2'b01);
    do_rd(8'hCD, "t5_m01_a");
    do_rd(8'hCD, "t5_m01_b");
    do_mode(2'b10);
    do_rd(8'hAB, "t5_m10_a");
    do_mode(2'b00);
    chk("t5_m00_ignored", data_out, 8'hAB);
    do_rd(8'hAB, "t5_m10_b");

    // mode_write overrides a simultaneous rd.
    do_mode(2'b11);
    count_high = 8'h12; count_low = 8'h34;
    do_latch();
    do_rd(8'h34, "t6_lsb");
    count_high = 8'h56; count_low = 8'h78;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 8'h12, "t6_rd_with_mode");
    chk("t6_latched_clr", {7'd0, count_latched}, 8'h00);
    chk("t6_data_lsb", data_out, 8'h78);
    do_rd(8'h78, "t6_live_lsb");

    // Asynchronous reset mid-sequence.
    do_mode(2'b10);
    status_in = 8'h3C;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, '0, "");
    chk("t7_pre_latched", {7'd0, count_latched}, 8'h01);
    chk("t7_pre_pending", {7'd0, status_pending}, 8'h01);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t7_rst_latched", {7'd0, count_latched}, 8'h00);
    chk("t7_rst_pending", {7'd0, status_pending}, 8'h00);
    chk("t7_rst_data", data_out, 8'h78);
    @(posedge clk); #1;
    reset = 1'b0;
    do_rd(8'h78, "t7_after_lsb");
    do_rd(8'h56, "t7_after_msb");

    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: remaining=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_readback.md
Name: count_readback

Overview:
- CPU-side read path of one 8254 counter channel; the reader for the counting element's running count.
- Takes the live 16-bit count (output_count_high/low) plus the channel status byte, and serves them byte-wise on an 8-bit read port.
- Honours the control-word read/write mode (LSB only, MSB only, LSB then MSB), the counter latch command and the status latch of the read-back command.
- Sits between counting_element and the bus interface / data-bus buffer.

Parameters:
- DATA_W, 8, byte width of the bus and of each count half.
- RW_RESET, 2'b11, read/write mode after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- count_high  input  DATA_W  live count MSB, from counting_element output_count_high.
- count_low  input  DATA_W  live count LSB, from counting_element output_count_low.
- status_in  input  DATA_W  live status byte (OUT pin, null-count, RW, mode, BCD).
- mode_write  input  1  one-cycle strobe: control word for this channel written.
- rw_mode  input  2  RW field of that control word; sampled only with mode_write.
- latch_cmd  input  1  one-cycle strobe: counter latch command.
- status_latch  input  1  one-cycle strobe: read-back command with status latch for this channel.
- rd  input  1  one-cycle strobe: CPU consumes the byte currently on data_out.
- data_out  output  DATA_W  byte the next rd returns.
- count_latched  output  1  a count latch is held.
- status_pending  output  1  a status latch is held.

Behaviour:
- Reset values: rw_reg=RW_RESET, byte_sel=LSB, count_latched=0, status_pending=0, latch_hi/lo=0, status_reg=0.
- data_out: combinational mux of registered state and live inputs; zero latency. Priority:
  - status_pending -> status_reg;
  - otherwise the byte picked by byte_sel from latch_hi/lo if count_latched, else from count_high/low.
- Byte selection by rw_reg:
  - 01: always LSB.
  - 10: always MSB.
  - 11: byte_sel toggles LSB->MSB->LSB on each count-byte rd.
- rd with status_pending:
  - consumes status;
  - clears status_pending;
  - byte_sel unchanged.
- rd without status_pending:
  - consumes a count byte;
  - in mode 11, toggles byte_sel;
  - releases the count latch (count_latched=0) when the byte read was the last byte of the sequence: any byte in 01/10, MSB in 11.
- latch_cmd:
  - if count_latched=0 after the same-edge rd is applied, capture {count_high,count_low} into latch_hi/lo and set count_latched.
  - otherwise ignored; the first latch wins until fully read.
- status_latch:
  - if status_pending=0, capture status_in and set status_pending;
  - otherwise ignored.
- mode_write with rw_mode != 00:
  - load rw_reg;
  - byte_sel=LSB;
  - clear count_latched and status_pending.
- mode_write with rw_mode=00: no effect. That encoding is the latch command and arrives on latch_cmd.
- Simultaneous events:
  - mode_write overrides rd, latch_cmd and status_latch in the same cycle.
  - rd is evaluated on pre-edge state first; latch_cmd and status_latch are then applied.
  - Example, mode 11, unlatched: rd+latch_cmd returns the live LSB and captures the count; the next rd returns the latched MSB and releases the latch.
- Unlatched mode-11 reads may straddle a count change (LSB and MSB from different counts). This matches 8254 behaviour and is not corrected.
- reset asserted mid-sequence: immediate return to reset values, independent of clk.
- rd with nothing special pending is always legal; it never blocks.

Decomposition:
- Shared package timer8254_pkg holds:
  - RW encodings RW_LATCH=2'b00, RW_LSB=2'b01, RW_MSB=2'b10, RW_LSB_MSB=2'b11;
  - BYTE_LSB/BYTE_MSB;
  - DATA_W.
- A sub-module byte_seq (rw_reg + byte_sel flip-flop with its toggle and last-byte logic) is natural. The bus-side write path reuses it for the LSB/MSB write sequencing.
- Latch and status registers stay in count_readback.

Test Plan:
- Reset, rw=11, live count 0x1234, two rd pulses -> data_out 0x34 then 0x12; count_latched stays 0.
- Live count 0x1234, latch_cmd, count advances to 0x1200, rd, rd -> 0x34, 0x12; count_latched 1 until the second rd edge, then 0; third rd returns the live LSB 0x00.
- Latched 0x1234, second latch_cmd while the count is 0x0F00 -> ignored; reads return 0x34, 0x12.
- status_in=0xB6, status_latch and latch_cmd together, count 0x00AA, three rd -> 0xB6, 0xAA, 0x00; status_pending clears after the first rd.
- rw=01 then rw=10 via mode_write, count 0xABCD -> mode 01 rd returns 0xCD; mode 10 rd returns 0xAB; mode_write with rw=00 leaves mode 10.
- Mode 11 after latch and one rd (byte_sel=MSB): mode_write rw=11 simultaneous with rd -> byte_sel=LSB, latch cleared, rd ignored. Separately, reset mid-sequence -> all flags 0 immediately.
